// File: rtl/data_ram_arbiter_if.sv
// Instruction/data request buses and single-port RAM bus shared by the arbiter.
// Zero-cycle grant, one-cycle read response, no response backpressure.
interface data_ram_arbiter_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_gnt;
    logic        inst_rvalid;
    logic [31:0] inst_rdata;

    logic        data_req;
    logic [3:0]  data_wen;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_gnt;
    logic        data_rvalid;
    logic [31:0] data_rdata;

    logic        ram_en;
    logic [3:0]  ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    modport slave (
        input  inst_req, inst_addr, data_req, data_wen, data_addr, data_wdata, ram_rdata,
        output inst_gnt, inst_rvalid, inst_rdata, data_gnt, data_rvalid, data_rdata,
               ram_en, ram_we, ram_addr, ram_wdata
    );

    modport master (
        output inst_req, inst_addr, data_req, data_wen, data_addr, data_wdata, ram_rdata,
        input  inst_gnt, inst_rvalid, inst_rdata, data_gnt, data_rvalid, data_rdata,
               ram_en, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/data_ram_arbiter.sv
// Inst/data arbiter for one single-port RAM, data-first; DRAM_ARB_STARVE_EN adds inst anti-starvation.
// Grant is same-cycle, read rvalid one cycle after grant; responses cannot be stalled.
module data_ram_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               reset,
    data_ram_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {RSP_IDLE, RSP_INST, RSP_DATA} rsp_state_t;

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_limit_check
        $error("STARVE_LIMIT must be in 1..15");
    end

    rsp_state_t state;
    logic       inst_gnt;
    logic       data_gnt;
    logic       inst_first;

`ifdef DRAM_ARB_STARVE_EN
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
    logic [3:0] starve_cnt;

    assign inst_first = (starve_cnt >= LIMIT);

    always_ff @(posedge clk) begin
        if (reset || !bus.inst_req || inst_gnt) begin
            starve_cnt <= 4'd0;
        end else if (starve_cnt != 4'd15) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end
`else
    assign inst_first = 1'b0;
`endif

    always_comb begin
        inst_gnt = 1'b0;
        data_gnt = 1'b0;
        if (!reset) begin
            if (bus.data_req && !(inst_first && bus.inst_req)) begin
                data_gnt = 1'b1;
            end else if (bus.inst_req) begin
                inst_gnt = 1'b1;
            end
        end
    end

    assign bus.inst_gnt  = inst_gnt;
    assign bus.data_gnt  = data_gnt;
    assign bus.ram_en    = inst_gnt | data_gnt;
    assign bus.ram_we    = data_gnt ? bus.data_wen : 4'b0000;
    assign bus.ram_addr  = data_gnt ? bus.data_addr : bus.inst_addr;
    assign bus.ram_wdata = bus.data_wdata;

    // Stores retire at grant, so only loads move the tracker to RSP_DATA.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RSP_IDLE;
        end else if (inst_gnt) begin
            state <= RSP_INST;
        end else if (data_gnt && bus.data_wen == 4'b0000) begin
            state <= RSP_DATA;
        end else begin
            state <= RSP_IDLE;
        end
    end

    // Gating with reset drops a response still in flight when reset arrives.
    assign bus.inst_rvalid = (state == RSP_INST) && !reset;
    assign bus.data_rvalid = (state == RSP_DATA) && !reset;
    assign bus.inst_rdata  = bus.ram_rdata;
    assign bus.data_rdata  = bus.ram_rdata;

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Directed vector bench for data_ram_arbiter with a simple RAM returning ~addr on reads.
module tb_data_ram_arbiter;

    logic clk;
    logic reset;
    int   n_run;
    int   n_fail;

    data_ram_arbiter_if bus ();

    data_ram_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.ram_en && bus.ram_we == 4'b0000) bus.ram_rdata <= ~bus.ram_addr;
    end

    typedef struct {
        logic        ireq;
        logic [31:0] iaddr;
        logic        dreq;
        logic [3:0]  dwen;
        logic [31:0] daddr;
        logic [31:0] dwdata;
        logic        eig;
        logic        edg;
        logic [3:0]  ewe;
        logic [31:0] eaddr;
        logic        eirv;
        logic        edrv;
    } vec_t;

    vec_t vecs[15];

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk32(name, {31'b0, act}, {31'b0, exp});
    endtask

    task automatic drive(input logic ireq, input logic [31:0] iaddr, input logic dreq,
                         input logic [3:0] dwen, input logic [31:0] daddr, input logic [31:0] dwdata);
        bus.inst_req   = ireq;
        bus.inst_addr  = iaddr;
        bus.data_req   = dreq;
        bus.data_wen   = dwen;
        bus.data_addr  = daddr;
        bus.data_wdata = dwdata;
    endtask

    task automatic chk_all_low(input string tag);
        chk1({tag, " inst_gnt"}, bus.inst_gnt, 1'b0);
        chk1({tag, " data_gnt"}, bus.data_gnt, 1'b0);
        chk1({tag, " ram_en"}, bus.ram_en, 1'b0);
        chk32({tag, " ram_we"}, {28'b0, bus.ram_we}, 32'h0);
        chk1({tag, " inst_rvalid"}, bus.inst_rvalid, 1'b0);
        chk1({tag, " data_rvalid"}, bus.data_rvalid, 1'b0);
    endtask

    task automatic chk_resp(input string tag, input vec_t v);
        chk1({tag, " inst_rvalid"}, bus.inst_rvalid, v.eirv);
        chk1({tag, " data_rvalid"}, bus.data_rvalid, v.edrv);
        if (v.eirv) chk32({tag, " inst_rdata"}, bus.inst_rdata, ~v.eaddr);
        if (v.edrv) chk32({tag, " data_rdata"}, bus.data_rdata, ~v.eaddr);
    endtask

    initial begin
        logic exp_ig;
        logic prev_ig;
        logic prev_dg;
        n_run  = 0;
        n_fail = 0;
        bus.ram_rdata = 32'h0;

        //            ireq  iaddr          dreq  dwen     daddr       dwdata        eig   edg   ewe      eaddr          eirv  edrv
        vecs[0]  = '{1'b1, 32'h1C000000, 1'b0, 4'h0,    32'h0,      32'h0,        1'b1, 1'b0, 4'h0,    32'h1C000000, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, 32'h00000200, 1'b1, 4'h0,    32'h100,    32'h0,        1'b0, 1'b1, 4'h0,    32'h00000100, 1'b0, 1'b1};
        vecs[2]  = '{1'b1, 32'h00000200, 1'b0, 4'h0,    32'h0,      32'h0,        1'b1, 1'b0, 4'h0,    32'h00000200, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 32'h0,        1'b1, 4'b0100, 32'h102,    32'h00AB0000, 1'b0, 1'b1, 4'b0100, 32'h00000102, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 32'h0,        1'b0, 4'h0,    32'h0,      32'h0,        1'b0, 1'b0, 4'h0,    32'h0,        1'b0, 1'b0};
        vecs[5]  = '{1'b1, 32'h00000010, 1'b0, 4'h0,    32'h0,      32'h0,        1'b1, 1'b0, 4'h0,    32'h00000010, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 32'h0,        1'b1, 4'h0,    32'h20,     32'h0,        1'b0, 1'b1, 4'h0,    32'h00000020, 1'b0, 1'b1};
        vecs[7]  = '{1'b1, 32'h00000014, 1'b0, 4'h0,    32'h0,      32'h0,        1'b1, 1'b0, 4'h0,    32'h00000014, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 32'h0,        1'b1, 4'h0,    32'h24,     32'h0,        1'b0, 1'b1, 4'h0,    32'h00000024, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 32'h00000018, 1'b0, 4'h0,    32'h0,      32'h0,        1'b1, 1'b0, 4'h0,    32'h00000018, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 32'h0,        1'b1, 4'h0,    32'h28,     32'h0,        1'b0, 1'b1, 4'h0,    32'h00000028, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 32'h0000001C, 1'b0, 4'h0,    32'h0,      32'h0,        1'b1, 1'b0, 4'h0,    32'h0000001C, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 32'h0,        1'b1, 4'h0,    32'h2C,     32'h0,        1'b0, 1'b1, 4'h0,    32'h0000002C, 1'b0, 1'b1};
        vecs[13] = '{1'b1, 32'h00000040, 1'b1, 4'hF,    32'h300,    32'h12345678, 1'b0, 1'b1, 4'hF,    32'h00000300, 1'b0, 1'b0};
        vecs[14] = '{1'b1, 32'h00000040, 1'b0, 4'h0,    32'h0,      32'h0,        1'b1, 1'b0, 4'h0,    32'h00000040, 1'b1, 1'b0};

        // Reset with both sides requesting: nothing may leak out.
        reset = 1'b1;
        drive(1'b1, 32'h1234, 1'b1, 4'hF, 32'h5678, 32'h9ABC);
        @(negedge clk);
        chk_all_low("rst0");
        @(negedge clk);
        chk_all_low("rst1");
        reset = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);

        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (i > 0) chk_resp($sformatf("v%0d resp", i - 1), vecs[i - 1]);
            drive(vecs[i].ireq, vecs[i].iaddr, vecs[i].dreq, vecs[i].dwen, vecs[i].daddr, vecs[i].dwdata);
            #1;
            chk1($sformatf("v%0d inst_gnt", i), bus.inst_gnt, vecs[i].eig);
            chk1($sformatf("v%0d data_gnt", i), bus.data_gnt, vecs[i].edg);
            chk1($sformatf("v%0d ram_en", i), bus.ram_en, vecs[i].eig | vecs[i].edg);
            chk32($sformatf("v%0d ram_we", i), {28'b0, bus.ram_we}, {28'b0, vecs[i].ewe});
            if (vecs[i].eig | vecs[i].edg)
                chk32($sformatf("v%0d ram_addr", i), bus.ram_addr, vecs[i].eaddr);
            if (vecs[i].edg)
                chk32($sformatf("v%0d ram_wdata", i), bus.ram_wdata, vecs[i].dwdata);
        end
        @(negedge clk);
        chk_resp("v14 resp", vecs[14]);
        drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);

        // Continuous contention: starvation pattern with the macro, pure data priority without.
        prev_ig = 1'b0;
        prev_dg = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (i > 0) begin
                chk1($sformatf("st%0d inst_rvalid", i - 1), bus.inst_rvalid, prev_ig);
                chk1($sformatf("st%0d data_rvalid", i - 1), bus.data_rvalid, prev_dg);
            end
            drive(1'b1, 32'h600, 1'b1, 4'h0, 32'h500, 32'h0);
            #1;
`ifdef DRAM_ARB_STARVE_EN
            exp_ig = ((i % 5) == 4);
`else
            exp_ig = 1'b0;
`endif
            chk1($sformatf("st%0d inst_gnt", i), bus.inst_gnt, exp_ig);
            chk1($sformatf("st%0d data_gnt", i), bus.data_gnt, !exp_ig);
            prev_ig = exp_ig;
            prev_dg = !exp_ig;
        end
        @(negedge clk);
        chk1("st14 inst_rvalid", bus.inst_rvalid, prev_ig);
        chk1("st14 data_rvalid", bus.data_rvalid, prev_dg);
        drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);

        // Reset right after a load grant must swallow its response.
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b1, 4'h0, 32'h700, 32'h0);
        #1;
        chk1("rl data_gnt", bus.data_gnt, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        drive(1'b1, 32'h900, 1'b1, 4'hF, 32'h704, 32'hFFFF);
        #1;
        chk_all_low("rl rst0");
        @(negedge clk);
        chk_all_low("rl rst1");
        reset = 1'b0;
        drive(1'b1, 32'h800, 1'b0, 4'h0, 32'h0, 32'h0);
        #1;
        chk1("post-rst inst_gnt", bus.inst_gnt, 1'b1);
        chk1("post-rst inst_rvalid", bus.inst_rvalid, 1'b0);
        chk1("post-rst data_rvalid", bus.data_rvalid, 1'b0);
        chk32("post-rst ram_addr", bus.ram_addr, 32'h800);
        @(negedge clk);
        chk1("post-rst resp inst_rvalid", bus.inst_rvalid, 1'b1);
        chk32("post-rst resp inst_rdata", bus.inst_rdata, ~32'h800);
        drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
